// File: rtl/lcd_bus_decoder.sv
// Decodes an 8080-style LCD write bus into pixel writes, display status
// flags and frame-wrap pulses. Bus strobes are synchronised into the clk domain.
module lcd_bus_decoder (
  input  logic        clk,
  input  logic        nrst,
  input  logic        csx,
  input  logic        wrx,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        disp_on,
  output logic        sleep_out,
  output logic        frame_done,
  output logic        cmd_err
);

  typedef enum logic [2:0] {IDLE, CASET_P, PASET_P, RAMWR_LO, RAMWR_HI} state_t;

  localparam logic [15:0] EC_RST = 16'd239;
  localparam logic [15:0] EP_RST = 16'd319;

  logic        r_wrxS1, r_wrxS2, r_wrxD3, r_csxS1, r_csxS2;
  logic        r_dcxS1, r_dcxS2;
  logic [7:0]  r_dS1, r_dS2;
  logic        w_wrStb;

  state_t      r_state, w_stateNext;
  logic [1:0]  r_idx, w_idxNext;
  logic [23:0] r_shadow, w_shadowNext;
  logic [15:0] r_sc, r_ec, r_sp, r_ep, w_scNext, w_ecNext, w_spNext, w_epNext;
  logic [15:0] r_cx, r_cy, w_cxNext, w_cyNext;
  logic [7:0]  r_lo, w_loNext;
  logic        r_pixValid, w_pixValidNext;
  logic [15:0] r_pixX, r_pixY, r_pixColor, w_pixXNext, w_pixYNext, w_pixColorNext;
  logic        r_dispOn, r_sleepOut, r_frameDone, r_cmdErr;
  logic        w_dispOnNext, w_sleepOutNext, w_frameDoneNext, w_cmdErrNext;

  // D and dcx ride two flops so they line up with the synchronised wrx edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wrxS1 <= 1'b1;
      r_wrxS2 <= 1'b1;
      r_wrxD3 <= 1'b1;
      r_csxS1 <= 1'b1;
      r_csxS2 <= 1'b1;
      r_dcxS1 <= 1'b0;
      r_dcxS2 <= 1'b0;
      r_dS1   <= 8'h00;
      r_dS2   <= 8'h00;
    end else begin
      r_wrxS1 <= wrx;
      r_wrxS2 <= r_wrxS1;
      r_wrxD3 <= r_wrxS2;
      r_csxS1 <= csx;
      r_csxS2 <= r_csxS1;
      r_dcxS1 <= dcx;
      r_dcxS2 <= r_dcxS1;
      r_dS1   <= D;
      r_dS2   <= r_dS1;
    end
  end

  assign w_wrStb = r_wrxS2 & ~r_wrxD3 & ~r_csxS2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_shadow    <= 24'h0;
      r_sc        <= 16'd0;
      r_ec        <= EC_RST;
      r_sp        <= 16'd0;
      r_ep        <= EP_RST;
      r_cx        <= 16'd0;
      r_cy        <= 16'd0;
      r_lo        <= 8'h00;
      r_pixValid  <= 1'b0;
      r_pixX      <= 16'd0;
      r_pixY      <= 16'd0;
      r_pixColor  <= 16'd0;
      r_dispOn    <= 1'b0;
      r_sleepOut  <= 1'b0;
      r_frameDone <= 1'b0;
      r_cmdErr    <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_idx       <= w_idxNext;
      r_shadow    <= w_shadowNext;
      r_sc        <= w_scNext;
      r_ec        <= w_ecNext;
      r_sp        <= w_spNext;
      r_ep        <= w_epNext;
      r_cx        <= w_cxNext;
      r_cy        <= w_cyNext;
      r_lo        <= w_loNext;
      r_pixValid  <= w_pixValidNext;
      r_pixX      <= w_pixXNext;
      r_pixY      <= w_pixYNext;
      r_pixColor  <= w_pixColorNext;
      r_dispOn    <= w_dispOnNext;
      r_sleepOut  <= w_sleepOutNext;
      r_frameDone <= w_frameDoneNext;
      r_cmdErr    <= w_cmdErrNext;
    end
  end

  // A command byte always aborts whatever sequence was in progress before it is decoded.
  always_comb begin
    w_stateNext     = r_state;
    w_idxNext       = r_idx;
    w_shadowNext    = r_shadow;
    w_scNext        = r_sc;
    w_ecNext        = r_ec;
    w_spNext        = r_sp;
    w_epNext        = r_ep;
    w_cxNext        = r_cx;
    w_cyNext        = r_cy;
    w_loNext        = r_lo;
    w_pixValidNext  = 1'b0;
    w_pixXNext      = r_pixX;
    w_pixYNext      = r_pixY;
    w_pixColorNext  = r_pixColor;
    w_dispOnNext    = r_dispOn;
    w_sleepOutNext  = r_sleepOut;
    w_frameDoneNext = 1'b0;
    w_cmdErrNext    = 1'b0;

    if (w_wrStb) begin
      if (!r_dcxS2) begin
        w_stateNext = IDLE;
        w_idxNext   = 2'd0;
        case (r_dS2)
          8'h00: ;
          8'h01: begin
            w_scNext       = 16'd0;
            w_ecNext       = EC_RST;
            w_spNext       = 16'd0;
            w_epNext       = EP_RST;
            w_cxNext       = 16'd0;
            w_cyNext       = 16'd0;
            w_pixXNext     = 16'd0;
            w_pixYNext     = 16'd0;
            w_pixColorNext = 16'd0;
            w_dispOnNext   = 1'b0;
            w_sleepOutNext = 1'b0;
          end
          8'h11: w_sleepOutNext = 1'b1;
          8'h28: w_dispOnNext = 1'b0;
          8'h29: w_dispOnNext = 1'b1;
          8'h2A: w_stateNext = CASET_P;
          8'h2B: w_stateNext = PASET_P;
          8'h2C: begin
            w_cxNext    = r_sc;
            w_cyNext    = r_sp;
            w_stateNext = RAMWR_LO;
          end
          default: w_cmdErrNext = 1'b1;
        endcase
      end else begin
        case (r_state)
          CASET_P, PASET_P: begin
            w_idxNext = r_idx + 2'd1;
            case (r_idx)
              2'd0: w_shadowNext[23:16] = r_dS2;
              2'd1: w_shadowNext[15:8]  = r_dS2;
              2'd2: w_shadowNext[7:0]   = r_dS2;
              default: begin
                w_stateNext = IDLE;
                if (r_state == CASET_P) begin
                  w_scNext = r_shadow[23:8];
                  w_ecNext = {r_shadow[7:0], r_dS2};
                end else begin
                  w_spNext = r_shadow[23:8];
                  w_epNext = {r_shadow[7:0], r_dS2};
                end
              end
            endcase
          end
          RAMWR_LO: begin
            w_loNext    = r_dS2;
            w_stateNext = RAMWR_HI;
          end
          RAMWR_HI: begin
            w_pixValidNext = 1'b1;
            w_pixXNext     = r_cx;
            w_pixYNext     = r_cy;
            w_pixColorNext = {r_dS2, r_lo};
            w_stateNext    = RAMWR_LO;
            if (r_cx != r_ec) begin
              w_cxNext = r_cx + 16'd1;
            end else if (r_cy != r_ep) begin
              w_cxNext = r_sc;
              w_cyNext = r_cy + 16'd1;
            end else begin
              w_cxNext        = r_sc;
              w_cyNext        = r_sp;
              w_frameDoneNext = 1'b1;
            end
          end
          default: w_cmdErrNext = 1'b1;
        endcase
      end
    end
  end

  assign pix_valid  = r_pixValid;
  assign pix_x      = r_pixX;
  assign pix_y      = r_pixY;
  assign pix_color  = r_pixColor;
  assign disp_on    = r_dispOn;
  assign sleep_out  = r_sleepOut;
  assign frame_done = r_frameDone;
  assign cmd_err    = r_cmdErr;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed-vector bench for lcd_bus_decoder: drives bus transactions and
// checks pixel reports, status flags and error pulses against hand-computed values.
module tb_lcd_bus_decoder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        csx = 1'b1;
  logic        wrx = 1'b1;
  logic        dcx = 1'b0;
  logic [7:0]  D = 8'h00;
  logic        pix_valid, disp_on, sleep_out, frame_done, cmd_err;
  logic [15:0] pix_x, pix_y, pix_color;

  int vectors = 0;
  int miscompares = 0;
  int errCount = 0;
  int frameCount = 0;
  logic [15:0] qx[$];
  logic [15:0] qy[$];
  logic [15:0] qc[$];
  logic        qf[$];

  lcd_bus_decoder dut (
    .clk(clk), .nrst(nrst), .csx(csx), .wrx(wrx), .dcx(dcx), .D(D),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .disp_on(disp_on), .sleep_out(sleep_out), .frame_done(frame_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Log every pulse one tick after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (pix_valid) begin
      qx.push_back(pix_x);
      qy.push_back(pix_y);
      qc.push_back(pix_color);
      qf.push_back(frame_done);
    end
    if (frame_done) frameCount++;
    if (cmd_err) errCount++;
  end

  task automatic clearLog();
    qx.delete(); qy.delete(); qc.delete(); qf.delete();
    errCount = 0;
    frameCount = 0;
  endtask

  task automatic busWrite(input logic dc, input logic [7:0] data);
    D = data;
    dcx = dc;
    @(negedge clk);
    wrx = 1'b0;
    repeat (3) @(negedge clk);
    wrx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] c);
    busWrite(1'b0, c);
  endtask

  task automatic dat(input logic [7:0] d);
    busWrite(1'b1, d);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pix_valid, pix_x, pix_y, pix_color, disp_on, sleep_out, frame_done, cmd_err} !== 53'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got x=%h y=%h c=%h flags=%b want all zero",
               pix_x, pix_y, pix_color, {pix_valid, disp_on, sleep_out, frame_done, cmd_err});
    end
    nrst = 1'b1;
    csx = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pix_valid, disp_on, sleep_out, cmd_err} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_flags got %b want 0000", {pix_valid, disp_on, sleep_out, cmd_err});
    end
  endtask

  task automatic test_single_pixel();
    logic [2:0] seen;
    clearLog();
    cmd(8'h2A); dat(8'h00); dat(8'h14); dat(8'h00); dat(8'h28);
    cmd(8'h2B); dat(8'h00); dat(8'h28); dat(8'h00); dat(8'h3C);
    cmd(8'h2C); dat(8'h00);
    D = 8'hF8;
    dcx = 1'b1;
    @(negedge clk);
    wrx = 1'b0;
    repeat (3) @(negedge clk);
    wrx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      seen[i] = pix_valid;
    end
    vectors++;
    if (seen !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL pixel_latency got valid per edge %b want 100", seen);
    end
    vectors++;
    if ({pix_x, pix_y, pix_color} !== {16'd20, 16'd40, 16'hF800}) begin
      miscompares++;
      $display("[TB] FAIL single_pixel got (%0d,%0d) %h want (20,40) f800", pix_x, pix_y, pix_color);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (qx.size() != 1 || frameCount != 0 || errCount != 0) begin
      miscompares++;
      $display("[TB] FAIL single_count got pix=%0d frame=%0d err=%0d want 1 0 0", qx.size(), frameCount, errCount);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] expY[3] = '{16'd40, 16'd41, 16'd40};
    logic        expF[3] = '{1'b0, 1'b1, 1'b0};
    clearLog();
    cmd(8'h2A); dat(8'h00); dat(8'h14); dat(8'h00); dat(8'h14);
    cmd(8'h2B); dat(8'h00); dat(8'h28); dat(8'h00); dat(8'h29);
    cmd(8'h2C);
    dat(8'h01); dat(8'h00);
    dat(8'h02); dat(8'h00);
    dat(8'hEF); dat(8'hBE);
    vectors++;
    if (qx.size() != 3 || frameCount != 1) begin
      miscompares++;
      $display("[TB] FAIL wrap_count got pix=%0d frame=%0d want 3 1", qx.size(), frameCount);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= qx.size() || qx[i] !== 16'd20 || qy[i] !== expY[i] || qf[i] !== expF[i]) begin
        miscompares++;
        $display("[TB] FAIL wrap_pixel%0d got (%0d,%0d) fd=%b want (20,%0d) fd=%b", i,
                 (i < qx.size()) ? qx[i] : 16'hFFFF, (i < qy.size()) ? qy[i] : 16'hFFFF,
                 (i < qf.size()) ? qf[i] : 1'bx, expY[i], expF[i]);
      end
    end
  endtask

  task automatic test_abort();
    clearLog();
    cmd(8'h2C);
    dat(8'h34);
    cmd(8'h00);
    dat(8'h12);
    vectors++;
    if (qx.size() != 0 || errCount != 1) begin
      miscompares++;
      $display("[TB] FAIL abort got pix=%0d err=%0d want 0 1", qx.size(), errCount);
    end
    vectors++;
    if ({pix_x, pix_y, pix_color} !== {16'd20, 16'd40, 16'hBEEF}) begin
      miscompares++;
      $display("[TB] FAIL hold_outputs got (%0d,%0d) %h want (20,40) beef", pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_csx_ignore();
    clearLog();
    cmd(8'h2C);
    csx = 1'b1;
    dat(8'h11); dat(8'h22);
    csx = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (qx.size() != 0 || errCount != 0) begin
      miscompares++;
      $display("[TB] FAIL csx_ignore got pix=%0d err=%0d want 0 0", qx.size(), errCount);
    end
    dat(8'h33); dat(8'h44);
    vectors++;
    if (qx.size() != 1 || pix_color !== 16'h4433 || pix_x !== 16'd20 || pix_y !== 16'd40) begin
      miscompares++;
      $display("[TB] FAIL csx_resume got n=%0d (%0d,%0d) %h want 1 (20,40) 4433", qx.size(), pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_status();
    clearLog();
    cmd(8'h11);
    cmd(8'h29);
    vectors++;
    if ({sleep_out, disp_on} !== 2'b11 || errCount != 0) begin
      miscompares++;
      $display("[TB] FAIL status_on got sleep=%b disp=%b err=%0d want 1 1 0", sleep_out, disp_on, errCount);
    end
    cmd(8'h28);
    cmd(8'h5A);
    vectors++;
    if ({sleep_out, disp_on} !== 2'b10 || errCount != 1) begin
      miscompares++;
      $display("[TB] FAIL status_off got sleep=%b disp=%b err=%0d want 1 0 1", sleep_out, disp_on, errCount);
    end
  endtask

  task automatic test_swreset();
    clearLog();
    cmd(8'h29);
    cmd(8'h01);
    vectors++;
    if ({sleep_out, disp_on, pix_x, pix_y, pix_color} !== 50'd0) begin
      miscompares++;
      $display("[TB] FAIL swreset_outputs got sleep=%b disp=%b (%0d,%0d) %h want all zero",
               sleep_out, disp_on, pix_x, pix_y, pix_color);
    end
    cmd(8'h2C); dat(8'h55); dat(8'h66);
    vectors++;
    if (qx.size() != 1 || pix_x !== 16'd0 || pix_y !== 16'd0 || pix_color !== 16'h6655) begin
      miscompares++;
      $display("[TB] FAIL swreset_window got n=%0d (%0d,%0d) %h want 1 (0,0) 6655", qx.size(), pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_partial_caset();
    clearLog();
    cmd(8'h2A); dat(8'h00); dat(8'h14);
    cmd(8'h2C);
    dat(8'h78); dat(8'h56);
    dat(8'h9A); dat(8'hBC);
    vectors++;
    if (qx.size() != 2 || errCount != 0) begin
      miscompares++;
      $display("[TB] FAIL partial_count got pix=%0d err=%0d want 2 0", qx.size(), errCount);
    end
    vectors++;
    if (qx.size() < 2 || qx[0] !== 16'd0 || qy[0] !== 16'd0 || qc[0] !== 16'h5678 || qx[1] !== 16'd1 || qy[1] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL partial_pixels got first (%0d,%0d) last (%0d,%0d) want (0,0) (1,0)",
               (qx.size() > 0) ? qx[0] : 16'hFFFF, (qy.size() > 0) ? qy[0] : 16'hFFFF, pix_x, pix_y);
    end
  endtask

  task automatic test_sc_gt_ec();
    clearLog();
    cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h03);
    cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
    cmd(8'h2C);
    dat(8'h01); dat(8'h00);
    dat(8'h02); dat(8'h00);
    vectors++;
    if (qx.size() != 2 || frameCount != 0 || qx[0] !== 16'd5 || qx[1] !== 16'd6 || qy[1] !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL no_clamp got n=%0d frame=%0d last (%0d,%0d) want 2 0 (6,0)", qx.size(), frameCount, pix_x, pix_y);
    end
  endtask

  task automatic test_reset_mid();
    clearLog();
    cmd(8'h2C);
    dat(8'hAA);
    nrst = 1'b0;
    #1;
    vectors++;
    if ({pix_valid, pix_x, pix_y, pix_color, disp_on, sleep_out, frame_done, cmd_err} !== 53'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs got (%0d,%0d) %h sleep=%b want all zero", pix_x, pix_y, pix_color, sleep_out);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    dat(8'hBB);
    vectors++;
    if (qx.size() != 0 || errCount != 1) begin
      miscompares++;
      $display("[TB] FAIL midreset_orphan got pix=%0d err=%0d want 0 1", qx.size(), errCount);
    end
    clearLog();
    cmd(8'h2C);
    for (int i = 0; i < 241; i++) begin
      dat(i[7:0]);
      dat(8'h00);
    end
    vectors++;
    if (qx.size() != 241 || frameCount != 0 || qx[239] !== 16'd239 || qy[239] !== 16'd0 || qx[240] !== 16'd0 || qy[240] !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL default_ec got n=%0d frame=%0d last (%0d,%0d) want 241 0 (0,1)", qx.size(), frameCount, pix_x, pix_y);
    end
    clearLog();
    cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
    cmd(8'h2C);
    for (int i = 0; i < 321; i++) begin
      dat(i[7:0]);
      dat(8'h00);
    end
    vectors++;
    if (qx.size() != 321 || frameCount != 1 || qy[318] !== 16'd318 || qf[318] !== 1'b0 || qy[319] !== 16'd319 || qf[319] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL default_ep got n=%0d frame=%0d want 321 1 with wrap at row 319", qx.size(), frameCount);
    end
    vectors++;
    if (pix_x !== 16'd0 || pix_y !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL ep_wrap_addr got (%0d,%0d) want (0,0)", pix_x, pix_y);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_wrap();
    test_abort();
    test_csx_ignore();
    test_status();
    test_swreset();
    test_partial_caset();
    test_sc_gt_ec();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
